// File: rtl/alu_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_operand_stage
// Brief    : ID/EX pipeline register with operand forwarding, immediate
//            extension and load-use hazard detection feeding the ALU.
// Revision : 1.0 - initial release
// ============================================================================
module alu_operand_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    // ID-side inputs
    input  logic        id_valid,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    input  logic [31:0] id_rs_val,
    input  logic [31:0] id_rt_val,
    input  logic [15:0] id_imm,
    input  logic        id_imm_sext,
    input  logic        id_alusrc,
    input  logic [3:0]  id_cmd,
    input  logic        id_regwrite,
    input  logic        id_memread,
    input  logic        id_memwrite,
    // forwarding sources
    input  logic        exm_regwrite,
    input  logic [4:0]  exm_rd,
    input  logic [31:0] exm_result,
    input  logic        wb_regwrite,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_result,
    // ALU side
    output logic [31:0] ex_opa,
    output logic [31:0] ex_opb,
    output logic [3:0]  ex_cmd,
    // downstream
    output logic        ex_valid,
    output logic [4:0]  ex_rd,
    output logic [31:0] ex_store_data,
    output logic        ex_regwrite,
    output logic        ex_memread,
    output logic        ex_memwrite,
    output logic        load_use_hazard
);

    localparam logic [4:0] c_reg_zero = 5'd0;

    // ID/EX register fields
    logic        valid_q;
    logic [4:0]  rs_q;
    logic [4:0]  rt_q;
    logic [4:0]  rd_q;
    logic [31:0] rs_val_q;
    logic [31:0] rt_val_q;
    logic [31:0] imm_q;
    logic        alusrc_q;
    logic [3:0]  cmd_q;
    logic        regwrite_q;
    logic        memread_q;
    logic        memwrite_q;

    logic [31:0] w_imm_ext;
    logic        w_hazard;
    logic [31:0] w_fwd_a;
    logic [31:0] w_fwd_b;

    // Immediate is widened at capture so EX never sees the 16-bit form
    assign w_imm_ext = id_imm_sext ? {{16{id_imm[15]}}, id_imm} : {16'h0000, id_imm};

    // A load sitting in EX whose destination is read by the instruction in ID
    assign w_hazard = valid_q & memread_q & (rd_q != c_reg_zero) & id_valid &
                      ((id_rs == rd_q) | (id_rt == rd_q));

    // Operand forwarding: the younger EX/MEM result beats MEM/WB; r0 never forwards
    always_comb begin
        w_fwd_a = rs_val_q;
        if (exm_regwrite && (exm_rd != c_reg_zero) && (exm_rd == rs_q)) begin
            w_fwd_a = exm_result;
        end else if (wb_regwrite && (wb_rd != c_reg_zero) && (wb_rd == rs_q)) begin
            w_fwd_a = wb_result;
        end

        w_fwd_b = rt_val_q;
        if (exm_regwrite && (exm_rd != c_reg_zero) && (exm_rd == rt_q)) begin
            w_fwd_b = exm_result;
        end else if (wb_regwrite && (wb_rd != c_reg_zero) && (wb_rd == rt_q)) begin
            w_fwd_b = wb_result;
        end
    end

    // Stage register update: reset, then bubble on flush, hold on stall,
    // bubble on load-use, otherwise capture the ID bundle
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            rs_q       <= 5'd0;
            rt_q       <= 5'd0;
            rd_q       <= 5'd0;
            rs_val_q   <= 32'd0;
            rt_val_q   <= 32'd0;
            imm_q      <= 32'd0;
            alusrc_q   <= 1'b0;
            cmd_q      <= 4'd0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
        end else if (flush || (!stall && w_hazard)) begin
            // Data fields are left as-is; nothing downstream uses them once valid drops
            valid_q    <= 1'b0;
            rd_q       <= 5'd0;
            cmd_q      <= 4'd0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
        end else if (!stall) begin
            valid_q    <= id_valid;
            rs_q       <= id_rs;
            rt_q       <= id_rt;
            rd_q       <= id_rd;
            rs_val_q   <= id_rs_val;
            rt_val_q   <= id_rt_val;
            imm_q      <= w_imm_ext;
            alusrc_q   <= id_alusrc;
            cmd_q      <= id_cmd;
            regwrite_q <= id_regwrite;
            memread_q  <= id_memread;
            memwrite_q <= id_memwrite;
        end
    end

    assign ex_opa          = w_fwd_a;
    assign ex_opb          = alusrc_q ? imm_q : w_fwd_b;
    assign ex_store_data   = w_fwd_b;
    assign ex_cmd          = cmd_q;
    assign ex_valid        = valid_q;
    assign ex_rd           = rd_q;
    assign ex_regwrite     = regwrite_q;
    assign ex_memread      = memread_q;
    assign ex_memwrite     = memwrite_q;
    assign load_use_hazard = w_hazard;

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_operand_stage
// Brief    : Self-checking bench: directed scenarios plus randomized traffic
//            compared every cycle against a behavioural stage model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_operand_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush;
    logic        id_valid, id_imm_sext, id_alusrc, id_regwrite, id_memread, id_memwrite;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_rs_val, id_rt_val;
    logic [15:0] id_imm;
    logic [3:0]  id_cmd;
    logic        exm_regwrite, wb_regwrite;
    logic [4:0]  exm_rd, wb_rd;
    logic [31:0] exm_result, wb_result;
    logic [31:0] ex_opa, ex_opb, ex_store_data;
    logic [3:0]  ex_cmd;
    logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite, load_use_hazard;
    logic [4:0]  ex_rd;

    int errors = 0;
    int checks = 0;

    alu_operand_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .id_imm(id_imm),
        .id_imm_sext(id_imm_sext), .id_alusrc(id_alusrc), .id_cmd(id_cmd),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
        .exm_regwrite(exm_regwrite), .exm_rd(exm_rd), .exm_result(exm_result),
        .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_result(wb_result),
        .ex_opa(ex_opa), .ex_opb(ex_opb), .ex_cmd(ex_cmd),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_store_data(ex_store_data),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
        .load_use_hazard(load_use_hazard)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic        m_known = 1'b0;
    logic        m_valid, m_alusrc, m_rw, m_mr, m_mw;
    logic [4:0]  m_rs, m_rt, m_rd;
    logic [31:0] m_rs_val, m_rt_val, m_imm;
    logic [3:0]  m_cmd;

    function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] v);
        if (exm_regwrite && exm_rd != 0 && exm_rd == r) return exm_result;
        if (wb_regwrite && wb_rd != 0 && wb_rd == r) return wb_result;
        return v;
    endfunction

    function automatic logic model_hazard();
        return m_known && m_valid && m_mr && m_rd != 0 && id_valid &&
               (id_rs == m_rd || id_rt == m_rd);
    endfunction

    always @(posedge clk) begin
        logic haz;
        logic signed [31:0] s;
        haz = model_hazard();
        s   = $signed(id_imm);
        if (rst) begin
            m_known <= 1'b1;
            m_valid <= 0; m_rw <= 0; m_mr <= 0; m_mw <= 0; m_rd <= 0; m_cmd <= 0;
            m_rs <= 0; m_rt <= 0; m_rs_val <= 0; m_rt_val <= 0; m_imm <= 0; m_alusrc <= 0;
        end else if (flush || (!stall && haz)) begin
            m_valid <= 0; m_rw <= 0; m_mr <= 0; m_mw <= 0; m_rd <= 0; m_cmd <= 0;
        end else if (!stall) begin
            m_valid <= id_valid; m_rs <= id_rs; m_rt <= id_rt; m_rd <= id_rd;
            m_rs_val <= id_rs_val; m_rt_val <= id_rt_val;
            m_imm <= id_imm_sext ? s : {16'h0, id_imm};
            m_alusrc <= id_alusrc; m_cmd <= id_cmd;
            m_rw <= id_regwrite; m_mr <= id_memread; m_mw <= id_memwrite;
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (m_known) begin
            check("valid", 32'(ex_valid), 32'(m_valid));
            check("rd", 32'(ex_rd), 32'(m_rd));
            check("cmd", 32'(ex_cmd), 32'(m_cmd));
            check("regwrite", 32'(ex_regwrite), 32'(m_rw));
            check("memread", 32'(ex_memread), 32'(m_mr));
            check("memwrite", 32'(ex_memwrite), 32'(m_mw));
            check("hazard", 32'(load_use_hazard), 32'(model_hazard()));
            if (m_valid) begin
                check("opa", ex_opa, fwd(m_rs, m_rs_val));
                check("opb", ex_opb, m_alusrc ? m_imm : fwd(m_rt, m_rt_val));
                check("store", ex_store_data, fwd(m_rt, m_rt_val));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall = 0; flush = 0; id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0;
        id_rs_val = 0; id_rt_val = 0; id_imm = 0; id_imm_sext = 0; id_alusrc = 0;
        id_cmd = 0; id_regwrite = 0; id_memread = 0; id_memwrite = 0;
        exm_regwrite = 0; exm_rd = 0; exm_result = 0;
        wb_regwrite = 0; wb_rd = 0; wb_result = 0;
    endtask

    initial begin
        idle();
        // reset asserted alongside flush/stall/load traffic
        rst = 1; stall = 1; flush = 1; id_valid = 1; id_memread = 1; id_rd = 5'd3;
        id_rs = 5'd3; id_cmd = 4'hF; id_regwrite = 1; id_memwrite = 1;
        tick(); tick();
        check("rst_valid", 32'(ex_valid), 0);
        check("rst_rd", 32'(ex_rd), 0);
        check("rst_cmd", 32'(ex_cmd), 0);
        check("rst_ctrl", {29'd0, ex_regwrite, ex_memread, ex_memwrite}, 0);
        check("rst_hazard", 32'(load_use_hazard), 0);
        rst = 0; idle();

        // basic capture
        id_valid = 1; id_rs = 3; id_rs_val = 32'h10; id_rt = 4; id_rt_val = 32'h20;
        id_rd = 1; id_cmd = 4'h0; id_regwrite = 1;
        tick();
        check("cap_opa", ex_opa, 32'h10);
        check("cap_opb", ex_opb, 32'h20);
        check("cap_valid", 32'(ex_valid), 1);

        // immediate extension
        id_alusrc = 1; id_imm = 16'hFFF0; id_imm_sext = 1;
        tick();
        check("imm_sext", ex_opb, 32'hFFFF_FFF0);
        check("imm_store", ex_store_data, 32'h20);
        id_imm_sext = 0;
        tick();
        check("imm_zext", ex_opb, 32'h0000_FFF0);

        // forwarding priority
        id_alusrc = 0; id_rs = 5; id_rs_val = 32'h55;
        tick();
        exm_regwrite = 1; exm_rd = 5; exm_result = 32'hAAAA;
        wb_regwrite = 1; wb_rd = 5; wb_result = 32'hBBBB;
        #1 check("fwd_exm", ex_opa, 32'hAAAA);
        exm_regwrite = 0;
        #1 check("fwd_wb", ex_opa, 32'hBBBB);
        wb_regwrite = 0;
        #1 check("fwd_none", ex_opa, 32'h55);
        id_rs = 0; id_rs_val = 32'h77;
        exm_regwrite = 1; exm_rd = 0; wb_regwrite = 1; wb_rd = 0;
        tick();
        check("fwd_r0", ex_opa, 32'h77);
        exm_regwrite = 0; wb_regwrite = 0;

        // load-use hazard
        id_memread = 1; id_rd = 7; id_rs = 1; id_rt = 2;
        tick();
        id_memread = 0; id_rs = 7; id_rd = 8;
        #1 check("lu_hazard", 32'(load_use_hazard), 1);
        tick();
        check("lu_bubble_valid", 32'(ex_valid), 0);
        check("lu_bubble_rw", 32'(ex_regwrite), 0);

        // stall hold and flush-over-stall
        id_rs = 2; id_rs_val = 32'h1234; id_rt = 3; id_rt_val = 32'h99; id_rd = 9; id_cmd = 4'h5;
        tick();
        check("st_cap", ex_opa, 32'h1234);
        stall = 1; id_rs_val = 32'hDEAD; id_valid = 0; id_cmd = 0; id_rd = 2;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("st_opa", ex_opa, 32'h1234);
            check("st_valid", 32'(ex_valid), 1);
            check("st_cmd_rd", {23'd0, ex_cmd, ex_rd}, {23'd0, 4'h5, 5'd9});
        end
        flush = 1;
        tick();
        check("fl_valid", 32'(ex_valid), 0);
        flush = 0; stall = 0;

        // reset in the middle of a stall
        id_valid = 1; id_memread = 1; id_rd = 4; id_cmd = 4'h3; id_memwrite = 1;
        tick();
        check("rs_pre", 32'(ex_valid), 1);
        stall = 1; rst = 1;
        tick();
        rst = 0;
        check("rs_valid", 32'(ex_valid), 0);
        check("rs_rd_cmd", {23'd0, ex_cmd, ex_rd}, 0);
        check("rs_ctrl", {29'd0, ex_regwrite, ex_memread, ex_memwrite}, 0);
        stall = 0;

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst   = ($urandom_range(63) == 0);
            stall = ($urandom_range(7) == 0);
            flush = ($urandom_range(15) == 0);
            id_valid = ($urandom_range(7) != 0);
            id_rs = 5'($urandom_range(7)); id_rt = 5'($urandom_range(7));
            id_rd = 5'($urandom_range(7));
            id_rs_val = $urandom; id_rt_val = $urandom; id_imm = 16'($urandom);
            id_imm_sext = 1'($urandom); id_alusrc = 1'($urandom); id_cmd = 4'($urandom);
            id_regwrite = 1'($urandom); id_memread = 1'($urandom); id_memwrite = 1'($urandom);
            exm_regwrite = 1'($urandom); exm_rd = 5'($urandom_range(7)); exm_result = $urandom;
            wb_regwrite = 1'($urandom); wb_rd = 5'($urandom_range(7)); wb_result = $urandom;
            tick();
        end
        rst = 0; idle();
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
